dcache_dm_wb: RTL

//  Direct-mapped, write-back, write-allocate data cache; initiator side of the slow_memory line protocol.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_line_array.sv | 72 +++++++
 rtl/dcache_dm_wb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and line helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int MEM_ADDR_W     = 28;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } state_e;

  // Word 0 of a line sits in bits [31:0].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        sel);
    line_word = line[WORD_W*sel +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Storage for NUM_LINES cache lines: valid, dirty, tag and 128-bit data.
// One asynchronous read port, one synchronous write port (refill or per-word store).
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDX_W-1:0]          idx,
  output logic                      rd_valid,
  output logic                      rd_dirty,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [LINE_W-1:0]         rd_data,
  input  logic                      fill_en,
  input  logic [TAG_W-1:0]          fill_tag,
  input  logic [LINE_W-1:0]         fill_data,
  input  logic [WORDS_PER_LINE-1:0] word_we,
  input  logic [LINE_W-1:0]         word_data
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [LINE_W-1:0]    data_d [NUM_LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  // A refill installs a clean line; a store marks the line dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
      data_d[idx]  = fill_data;
    end else if (|word_we) begin
      dirty_d[idx] = 1'b1;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        if (word_we[w]) begin
          data_d[idx][w*WORD_W +: WORD_W] = word_data[w*WORD_W +: WORD_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the core data
// port and a slow line-based memory. Top level holds the FSM and muxing only.
module dcache_dm_wb
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int ADDR_W    = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_e state_q, state_d;

  logic [IDX_W-1:0]          idx;
  logic [TAG_W-1:0]          tag;
  logic [1:0]                word_sel;
  logic                      req;
  logic                      hit;
  logic                      rd_valid;
  logic                      rd_dirty;
  logic [TAG_W-1:0]          rd_tag;
  logic [LINE_W-1:0]         rd_data;
  logic                      fill_en;
  logic [WORDS_PER_LINE-1:0] word_we;

  assign idx       = proc_addr[IDX_W+1:2];
  assign tag       = proc_addr[ADDR_W-1:IDX_W+2];
  assign word_sel  = proc_addr[1:0];
  assign req       = proc_read | proc_write;
  assign hit       = rd_valid && (rd_tag == tag);
  assign dbg_state = state_q;

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_data (mem_rdata),
    .word_we   (word_we),
    .word_data ({WORDS_PER_LINE{proc_wdata}})
  );

  // Memory handshake: mem_read/mem_write are pure functions of state, so the
  // request, address and write data stay stable until mem_ready (a one-cycle
  // completion pulse) is sampled; the two requests are never high together.
  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    proc_stall = 1'b0;
    proc_rdata = '0;
    fill_en    = 1'b0;
    word_we    = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            // A combined read+write is a store and returns no data.
            if (proc_write) begin
              word_we[word_sel] = 1'b1;
            end else begin
              proc_rdata = line_word(rd_data, word_sel);
            end
          end else begin
            proc_stall = 1'b1;
            state_d    = (rd_valid && rd_dirty) ? S_WB : S_ALLOC;
          end
        end
      end
      S_WB: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = MEM_ADDR_W'({rd_tag, idx});
        mem_wdata  = rd_data;
        if (mem_ready) begin
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = MEM_ADDR_W'(proc_addr[ADDR_W-1:2]);
        // The access replays in S_IDLE, so a store merges after the refill.
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
